// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the stage sequencer and its environment.
// Inputs are decoded instruction flags and run control; outputs are the registered stage code and status.
interface stage_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             Start;
    logic             Halt_Req;
    logic             Halt_Instr;
    logic             NOP_FLAG;
    logic             WillWriteTo_Memory_H_RF_L;
    logic             Step_Mode;
    logic [2:0]       Stage;
    logic             Busy;
    logic             Halted;
    logic [CNT_W-1:0] Instr_Count;

    // No valid/ready pair: inputs are level signals sampled on every rising
    // clock edge, and outputs are registered and valid in every cycle.
    modport master (
        output Start, Halt_Req, Halt_Instr, NOP_FLAG, WillWriteTo_Memory_H_RF_L, Step_Mode,
        input  Stage, Busy, Halted, Instr_Count
    );

    modport slave (
        input  Start, Halt_Req, Halt_Instr, NOP_FLAG, WillWriteTo_Memory_H_RF_L, Step_Mode,
        output Stage, Busy, Halted, Instr_Count
    );
endinterface

// File: rtl/stage_sequencer.sv
// Steps one instruction at a time through Fetch..Write Back (Stage 1..5), with NOP shortening,
// Memory-stage stretching for RAM writes, halt and single-step; o_state exposes the FSM state.
module stage_sequencer #(
    parameter int NOP_SKIP = 1,
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic                 Clock,
    input  logic                 Reset_L,
    stage_sequencer_if.slave     bus,
    output logic [1:0]           o_state
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_MWAIT  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [3:0] MEM_WAIT_L = 4'(MEM_WAIT);
    localparam bit         SKIP_EN    = (NOP_SKIP != 0);
    localparam bit         WAIT_EN    = (MEM_WAIT > 0);

    state_t           r_state;
    logic [2:0]       r_stage;
    logic             r_busy;
    logic             r_halted;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_wait_ctr;
    logic             r_halt_pend;

    logic             w_halt_now;
    state_t           w_cmp_state;
    logic [2:0]       w_cmp_stage;

    assign w_halt_now = r_halt_pend | bus.Halt_Req;

    // Where an instruction goes once it retires (leaving Stage 5 or a skipped NOP).
    always_comb begin
        w_cmp_state = S_RUN;
        w_cmp_stage = 3'd1;
        if (w_halt_now) begin
            w_cmp_state = S_HALTED;
            w_cmp_stage = 3'd0;
        end else if (bus.Step_Mode) begin
            w_cmp_state = S_IDLE;
            w_cmp_stage = 3'd0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state     <= S_IDLE;
            r_stage     <= 3'd0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_count     <= '0;
            r_wait_ctr  <= 4'd0;
            r_halt_pend <= 1'b0;
        end else if (r_stage > 3'd5) begin
            r_state  <= S_IDLE;
            r_stage  <= 3'd0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_halt_now) begin
                        r_state     <= S_HALTED;
                        r_halted    <= 1'b1;
                        r_halt_pend <= 1'b0;
                    end else if (bus.Start) begin
                        r_state <= S_RUN;
                        r_stage <= 3'd1;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.Halt_Req) r_halt_pend <= 1'b1;
                    case (r_stage)
                        3'd1: r_stage <= 3'd2;
                        3'd2: begin
                            if (bus.Halt_Instr) begin
                                r_count     <= r_count + CNT_W'(1);
                                r_state     <= S_HALTED;
                                r_stage     <= 3'd0;
                                r_busy      <= 1'b0;
                                r_halted    <= 1'b1;
                                r_halt_pend <= 1'b0;
                            end else if (bus.NOP_FLAG && SKIP_EN) begin
                                r_count  <= r_count + CNT_W'(1);
                                r_state  <= w_cmp_state;
                                r_stage  <= w_cmp_stage;
                                r_busy   <= (w_cmp_stage != 3'd0);
                                r_halted <= (w_cmp_state == S_HALTED);
                                if (w_halt_now) r_halt_pend <= 1'b0;
                            end else begin
                                r_stage <= 3'd3;
                            end
                        end
                        3'd3: r_stage <= 3'd4;
                        3'd4: begin
                            if (bus.WillWriteTo_Memory_H_RF_L && WAIT_EN) begin
                                r_state    <= S_MWAIT;
                                r_wait_ctr <= MEM_WAIT_L;
                            end else begin
                                r_stage <= 3'd5;
                            end
                        end
                        3'd5: begin
                            r_count  <= r_count + CNT_W'(1);
                            r_state  <= w_cmp_state;
                            r_stage  <= w_cmp_stage;
                            r_busy   <= (w_cmp_stage != 3'd0);
                            r_halted <= (w_cmp_state == S_HALTED);
                            if (w_halt_now) r_halt_pend <= 1'b0;
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_stage <= 3'd0;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
                S_MWAIT: begin
                    // Stage 4 is held here, so the RAM write strobe simply repeats.
                    if (bus.Halt_Req) r_halt_pend <= 1'b1;
                    if (r_wait_ctr <= 4'd1) begin
                        r_state    <= S_RUN;
                        r_stage    <= 3'd5;
                        r_wait_ctr <= 4'd0;
                    end else begin
                        r_wait_ctr <= r_wait_ctr - 4'd1;
                    end
                end
                S_HALTED: begin
                    r_stage  <= 3'd0;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stage <= 3'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Stage       = r_stage;
    assign bus.Busy        = r_busy;
    assign bus.Halted      = r_halted;
    assign bus.Instr_Count = r_count;
    assign o_state         = r_state;
endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: dut_a (NOP skip, 2-cycle memory wait, 4-bit counter) and
// dut_b (no NOP skip, no memory wait, 16-bit counter) share clock and reset.
module tb_stage_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [20:0] exp_q[$];
    logic [1:0]  dbg_a, dbg_b;

    always #5 clk = ~clk;

    stage_sequencer_if #(.CNT_W(4))  ifa ();
    stage_sequencer_if #(.CNT_W(16)) ifb ();

    stage_sequencer #(.NOP_SKIP(1), .MEM_WAIT(2), .CNT_W(4)) dut_a (
        .Clock(clk), .Reset_L(rst_n), .bus(ifa.slave), .o_state(dbg_a)
    );
    stage_sequencer #(.NOP_SKIP(0), .MEM_WAIT(0), .CNT_W(16)) dut_b (
        .Clock(clk), .Reset_L(rst_n), .bus(ifb.slave), .o_state(dbg_b)
    );

    // Expected word: {Halted, Busy, Stage, Instr_Count[15:0]}
    function automatic logic [20:0] mk(input logic h, input int st, input int c);
        logic [2:0]  s;
        logic [15:0] cc;
        s  = st[2:0];
        cc = c[15:0];
        return {h, (s != 3'd0), s, cc};
    endfunction

    function automatic logic [20:0] obs_a();
        return {ifa.Halted, ifa.Busy, ifa.Stage, 12'd0, ifa.Instr_Count};
    endfunction

    function automatic logic [20:0] obs_b();
        return {ifb.Halted, ifb.Busy, ifb.Stage, ifb.Instr_Count};
    endfunction

    task automatic drive_idle();
        ifa.Start = 0; ifa.Halt_Req = 0; ifa.Halt_Instr = 0; ifa.NOP_FLAG = 0;
        ifa.WillWriteTo_Memory_H_RF_L = 0; ifa.Step_Mode = 0;
        ifb.Start = 0; ifb.Halt_Req = 0; ifb.Halt_Instr = 0; ifb.NOP_FLAG = 0;
        ifb.WillWriteTo_Memory_H_RF_L = 0; ifb.Step_Mode = 0;
    endtask

    task automatic apply_reset();
        drive_idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [20:0] e;
        apply_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 0, 0));
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== e) $display("FAIL reset_a[%0d]: got %h want %h", i, obs_a(), e);
            else n_pass++;
            n_checks++;
            if (obs_b() !== e) $display("FAIL reset_b[%0d]: got %h want %h", i, obs_b(), e);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic [20:0] e;
        apply_reset();
        ifa.Start = 1;
        for (int n = 0; n < 16; n++)
            for (int s = 1; s <= 5; s++) exp_q.push_back(mk(0, s, n % 16));
        exp_q.push_back(mk(0, 1, 16 % 16));
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== e) $display("FAIL basic[%0d]: got %h want %h", i, obs_a(), e);
            else n_pass++;
        end
        ifa.Start = 0;
    endtask

    task automatic test_nop_skip();
        logic [20:0] e;
        apply_reset();
        ifa.Start = 1;
        ifa.NOP_FLAG = 1;
        exp_q.push_back(mk(0, 1, 0)); exp_q.push_back(mk(0, 2, 0));
        exp_q.push_back(mk(0, 1, 1)); exp_q.push_back(mk(0, 2, 1));
        exp_q.push_back(mk(0, 1, 2));
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== e) $display("FAIL nop_skip[%0d]: got %h want %h", i, obs_a(), e);
            else n_pass++;
        end
    endtask

    task automatic test_nop_full();
        logic [20:0] e;
        apply_reset();
        ifb.Start = 1;
        ifb.NOP_FLAG = 1;
        for (int s = 1; s <= 5; s++) exp_q.push_back(mk(0, s, 0));
        exp_q.push_back(mk(0, 1, 1));
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_b() !== e) $display("FAIL nop_full[%0d]: got %h want %h", i, obs_b(), e);
            else n_pass++;
        end
    endtask

    task automatic test_mem_wait();
        logic [20:0] e;
        apply_reset();
        ifa.Start = 1;
        ifa.WillWriteTo_Memory_H_RF_L = 1;
        exp_q.push_back(mk(0, 1, 0)); exp_q.push_back(mk(0, 2, 0));
        exp_q.push_back(mk(0, 3, 0)); exp_q.push_back(mk(0, 4, 0));
        exp_q.push_back(mk(0, 4, 0)); exp_q.push_back(mk(0, 4, 0));
        exp_q.push_back(mk(0, 5, 0)); exp_q.push_back(mk(0, 1, 1));
        exp_q.push_back(mk(0, 2, 1));
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== e) $display("FAIL mem_wait[%0d]: got %h want %h", i, obs_a(), e);
            else n_pass++;
        end
        apply_reset();
        ifb.Start = 1;
        ifb.WillWriteTo_Memory_H_RF_L = 1;
        for (int s = 1; s <= 5; s++) exp_q.push_back(mk(0, s, 0));
        exp_q.push_back(mk(0, 1, 1));
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_b() !== e) $display("FAIL mem_nowait[%0d]: got %h want %h", i, obs_b(), e);
            else n_pass++;
        end
    endtask

    task automatic test_halt_req();
        logic [20:0] e;
        apply_reset();
        ifa.Start = 1;
        for (int s = 1; s <= 5; s++) exp_q.push_back(mk(0, s, 0));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 0, 1));
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== e) $display("FAIL halt_req[%0d]: got %h want %h", i, obs_a(), e);
            else n_pass++;
            ifa.Halt_Req = (i == 2);
            if (i == 6) ifa.Step_Mode = 1;
        end
    endtask

    task automatic test_halt_instr();
        logic [20:0] e;
        apply_reset();
        ifa.Start = 1;
        ifa.Halt_Instr = 1;
        ifa.NOP_FLAG = 1;
        exp_q.push_back(mk(0, 1, 0)); exp_q.push_back(mk(0, 2, 0));
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1, 0, 1));
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== e) $display("FAIL halt_instr[%0d]: got %h want %h", i, obs_a(), e);
            else n_pass++;
        end
    endtask

    task automatic test_halt_idle();
        logic [20:0] e;
        apply_reset();
        ifa.Start = 1;
        ifa.Halt_Req = 1;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1, 0, 0));
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== e) $display("FAIL halt_idle[%0d]: got %h want %h", i, obs_a(), e);
            else n_pass++;
            ifa.Halt_Req = 0;
        end
    endtask

    task automatic test_step();
        logic [20:0] e;
        apply_reset();
        ifa.Step_Mode = 1;
        ifa.Start = 1;
        for (int s = 1; s <= 5; s++) exp_q.push_back(mk(0, s, 0));
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 0, 1));
        for (int s = 1; s <= 5; s++) exp_q.push_back(mk(0, s, 1));
        for (int i = 0; i < 2; i++) exp_q.push_back(mk(0, 0, 2));
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== e) $display("FAIL step[%0d]: got %h want %h", i, obs_a(), e);
            else n_pass++;
            ifa.Start = (i == 7);
        end
    endtask

    task automatic test_reset_mid();
        logic [20:0] e;
        apply_reset();
        ifa.Start = 1;
        for (int s = 1; s <= 5; s++) exp_q.push_back(mk(0, s, 0));
        for (int s = 1; s <= 3; s++) exp_q.push_back(mk(0, s, 1));
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a() !== e) $display("FAIL reset_mid_run[%0d]: got %h want %h", i, obs_a(), e);
            else n_pass++;
        end
        #2 rst_n = 1'b0;
        #1;
        e = mk(0, 0, 0);
        n_checks++;
        if (obs_a() !== e) $display("FAIL reset_async: got %h want %h", obs_a(), e);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        ifa.Start = 0;
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_basic();
        test_nop_skip();
        test_nop_full();
        test_mem_wait();
        test_halt_req();
        test_halt_instr();
        test_halt_idle();
        test_step();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
